// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - signed restoring shift-subtract divider, one quotient bit per clock
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_reg_q, q_reg_d;
  logic [WIDTH-1:0] d_reg_q, d_reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // One guard bit above A keeps the trial-subtraction sign visible after the shift.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {a_q, q_reg_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, d_reg_q};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_reg_d     = q_reg_q;
    d_reg_d     = d_reg_q;
    cnt_d       = cnt_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end else begin
            neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_d = dividend[WIDTH-1];
            q_reg_d = dividend[WIDTH-1] ? -dividend : dividend;
            d_reg_d = divisor[WIDTH-1] ? -divisor : divisor;
            a_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH+1]) begin
          a_d     = trial[WIDTH:0];
          q_reg_d = {q_reg_q[WIDTH-2:0], 1'b1};
        end else begin
          a_d     = shifted[WIDTH:0];
          q_reg_d = {q_reg_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = neg_q_q ? -q_reg_q : q_reg_q;
        remainder_d = neg_r_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_reg_q     <= '0;
      d_reg_q     <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_reg_q     <= q_reg_d;
      d_reg_q     <= d_reg_d;
      cnt_q       <= cnt_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - directed-vector bench for sequential_divider
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;

  sequential_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Counts edges after acceptance until done is seen, sampling 1 time unit past each edge.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                     input int elat);
    int lat, busy_n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, busy_n);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_busy"}, 32'(busy_n), edbz ? 32'd0 : 32'(elat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, busy_n, seen;
    #1;
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_ctl", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run("n100_7", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 33);
    run("p100_n7", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 33);
    run("n100_n7", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 33);
    run("dbz", 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
    run("p5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    run("max_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 33);

    // Start held high with changing operands; the done-cycle start is accepted back-to-back.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd77;
    divisor  = 32'd4;
    wait_done(lat, busy_n);
    chk("hold_lat", 32'(lat), 32'd33);
    chk("hold_q", quotient, 32'd333);
    chk("hold_r", remainder, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_ctl", {30'd0, busy, done}, 32'd2);
    wait_done(lat, busy_n);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_q", quotient, 32'd19);
    chk("b2b_r", remainder, 32'd1);

    // Reset in the middle of 100/7 aborts without a done pulse.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_ctl", {30'd0, busy, done}, 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);
    run("p50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
